// File: rtl/sd_clk_pkg.sv
// Shared types and helpers for the SD card clock generator.
// Holds the phase state encoding, the default divisor width and the zero-divisor clamp.
package sd_clk_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_PARK = 2'd2
  } state_e;

  // A programmed divisor of 0 would give an empty half-period, so it runs as 1.
  function automatic logic [31:0] div_clamp(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/sd_clk_gen_if.sv
// Host-side bundle of the SD clock generator: divisor/select/enable controls in, card clock and strobes out.
// The master modport is the host controller, the slave modport is the generator.
interface sd_clk_gen_if #(
  parameter int DIV_W = 8
);

  logic [DIV_W-1:0] idiv_slow;
  logic [DIV_W-1:0] idiv_fast;
  logic             isel_clk;
  logic             ien;
  logic             oclk_sd;
  logic             orise;
  logic             ofall;
  logic             olocked;
  logic             ostopped;

  modport master (
    output idiv_slow, idiv_fast, isel_clk, ien,
    input  oclk_sd, orise, ofall, olocked, ostopped
  );

  modport slave (
    input  idiv_slow, idiv_fast, isel_clk, ien,
    output oclk_sd, orise, ofall, olocked, ostopped
  );

endinterface

// File: rtl/sd_clk_half_cnt.sv
// Saturating half-period counter: load clears it, otherwise it climbs to term_i and holds there.
// tc_o is high combinationally whenever the count has reached term_i.
module sd_clk_half_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // >= rather than == keeps the flag asserted even if term_i ever drops below the count.
  assign tc_o = (cnt_q >= term_i);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (!tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_clk_gen.sv
// Glitch-free SD card clock divider with slow/fast divisors latched only at rising edges, plus park-low on ien=0.
// oclk_sd is registered; orise/ofall flag the cycle before each card clock edge.
module sd_clk_gen
  import sd_clk_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter bit RST_SEL = 1'b0
) (
  input  logic         iclk,
  input  logic         irst,
  sd_clk_gen_if.slave  bus
);

  state_e           state_q, state_d;
  logic             sel_act_q, sel_act_d;
  logic [DIV_W-1:0] n_act_q, n_act_d;
  logic             init_q;
  logic             oclk_q, oclk_d;
  logic             locked_q, locked_d;

  logic [DIV_W-1:0] n_sel;
  logic [DIV_W-1:0] n_rst;
  logic [DIV_W-1:0] n_cur;
  logic             tc;
  logic             cnt_load;
  logic             rise;
  logic             fall;

  assign n_sel = DIV_W'(div_clamp(32'(bus.isel_clk ? bus.idiv_fast : bus.idiv_slow)));
  assign n_rst = DIV_W'(div_clamp(32'(sel_act_q ? bus.idiv_fast : bus.idiv_slow)));

  // Until the first clock after reset the divisor has never been sampled, so the live value is used.
  assign n_cur = init_q ? n_rst : n_act_q;

  sd_clk_half_cnt #(
    .W (DIV_W)
  ) u_half_cnt (
    .clk_i  (iclk),
    .rst_i  (irst),
    .load_i (cnt_load),
    .term_i (n_cur - DIV_W'(1)),
    .tc_o   (tc)
  );

  always_comb begin
    state_d   = state_q;
    sel_act_d = sel_act_q;
    n_act_d   = n_cur;
    locked_d  = locked_q;
    rise      = 1'b0;
    fall      = 1'b0;
    cnt_load  = 1'b0;

    case (state_q)
      ST_HIGH: begin
        if (tc) begin
          fall     = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (tc) begin
          if (bus.ien) begin
            rise = 1'b1;
          end else begin
            state_d = ST_PARK;
          end
        end
      end
      ST_PARK: begin
        if (bus.ien) begin
          rise = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase

    // The divisor and selection only move at a rise, so a whole period always uses one N.
    if (rise) begin
      state_d   = ST_HIGH;
      cnt_load  = 1'b1;
      sel_act_d = bus.isel_clk;
      n_act_d   = n_sel;
      locked_d  = 1'b1;
    end

    oclk_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q   <= ST_LOW;
      sel_act_q <= RST_SEL;
      n_act_q   <= DIV_W'(1);
      init_q    <= 1'b1;
      oclk_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_act_q <= sel_act_d;
      n_act_q   <= n_act_d;
      init_q    <= 1'b0;
      oclk_q    <= oclk_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.oclk_sd  = oclk_q;
  assign bus.orise    = rise & ~irst;
  assign bus.ofall    = fall & ~irst;
  assign bus.olocked  = locked_q & (bus.isel_clk == sel_act_q);
  assign bus.ostopped = (state_q == ST_PARK);

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: directed scenarios with literal expectations, then random traffic against a timeline model.
module tb_sd_clk_gen;

  localparam int DIV_W   = 8;
  localparam bit RST_SEL = 1'b1;

  logic iclk = 1'b0;
  logic irst;

  sd_clk_gen_if #(.DIV_W(DIV_W)) bus ();

  sd_clk_gen #(
    .DIV_W   (DIV_W),
    .RST_SEL (RST_SEL)
  ) dut (
    .iclk (iclk),
    .irst (irst),
    .bus  (bus)
  );

  always #5 iclk = ~iclk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clampn(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Timeline model: a rise at cycle r with half-period N gives high cycles r+1..r+N,
  // a fall strobe at r+N, and the next rise no earlier than r+2N (later if ien is low then).
  int mc = 0;
  int m_n, m_last, m_early;
  bit m_sel, m_lock, m_have;
  logic e_oclk, e_rise, e_fall, e_stop, e_lock;

  always @(negedge iclk) begin
    #2;
    if (irst) begin
      chk("rst_oclk",   bus.oclk_sd,  0);
      chk("rst_rise",   bus.orise,    0);
      chk("rst_fall",   bus.ofall,    0);
      chk("rst_locked", bus.olocked,  0);
      chk("rst_stop",   bus.ostopped, 0);
      mc = 0;
    end else begin
      if (mc == 0) begin
        m_sel   = RST_SEL;
        m_n     = clampn(RST_SEL ? int'(bus.idiv_fast) : int'(bus.idiv_slow));
        m_lock  = 1'b0;
        m_have  = 1'b0;
        m_last  = 0;
        m_early = m_n - 1;
      end
      e_oclk = m_have && (mc > m_last) && (mc <= m_last + m_n);
      e_fall = m_have && (mc == m_last + m_n);
      e_rise = (mc >= m_early) && bus.ien;
      e_stop = (mc > m_early);
      e_lock = m_lock && (bus.isel_clk == m_sel);
      chk("m_oclk",   bus.oclk_sd,  e_oclk);
      chk("m_rise",   bus.orise,    e_rise);
      chk("m_fall",   bus.ofall,    e_fall);
      chk("m_stop",   bus.ostopped, e_stop);
      chk("m_locked", bus.olocked,  e_lock);
      if (e_rise) begin
        m_have  = 1'b1;
        m_last  = mc;
        m_sel   = bus.isel_clk;
        m_n     = clampn(bus.isel_clk ? int'(bus.idiv_fast) : int'(bus.idiv_slow));
        m_lock  = 1'b1;
        m_early = mc + 2 * m_n;
      end
      mc++;
    end
  end

  logic             nx_rst, nx_ien, nx_sel;
  logic [DIV_W-1:0] nx_slow, nx_fast;
  int k = -1;

  // Inputs change on the falling edge; outputs are sampled 3 time units later.
  task automatic step();
    @(negedge iclk);
    irst          = nx_rst;
    bus.ien       = nx_ien;
    bus.isel_clk  = nx_sel;
    bus.idiv_slow = nx_slow;
    bus.idiv_fast = nx_fast;
    #3;
    if (irst) k = -1;
    else k++;
  endtask

  task automatic wait_rise(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.orise && n < 1000);
    if (!bus.orise) chk(name, 0, 1);
  endtask

  task automatic count_while(input logic lvl, output int n);
    n = 0;
    while (bus.oclk_sd == lvl && n < 1000) begin
      n++;
      step();
    end
  endtask

  task automatic wait_stop(output int n);
    n = 0;
    while (!bus.ostopped && n < 1000) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    nx_rst = 1'b1; nx_ien = 1'b1; nx_sel = 1'b1;
    nx_slow = 8'd100; nx_fast = 8'd2;
    irst = 1'b1; bus.ien = 1'b1; bus.isel_clk = 1'b1;
    bus.idiv_slow = 8'd100; bus.idiv_fast = 8'd2;

    repeat (3) step();
    chk("reset_oclk", bus.oclk_sd, 0);
    chk("reset_locked", bus.olocked, 0);

    // Fast N=2 from reset: rise at cycle 1, period 4.
    nx_rst = 1'b0;
    step(); chk("c0_rise", bus.orise, 0);
    step(); chk("c1_rise", bus.orise, 1); chk("c1_locked", bus.olocked, 0);
    step(); chk("c2_oclk", bus.oclk_sd, 1); chk("c2_locked", bus.olocked, 1);
    step(); chk("c3_fall", bus.ofall, 1);
    step(); chk("c4_oclk", bus.oclk_sd, 0);
    step(); chk("c5_rise", bus.orise, 1);
    step(); chk("c6_oclk", bus.oclk_sd, 1);

    // Switch to slow (100) in the middle of a fast high phase.
    nx_sel = 1'b0;
    step(); chk("c7_fall", bus.ofall, 1); chk("c7_locked", bus.olocked, 0);
    step(); chk("c8_oclk", bus.oclk_sd, 0);
    step(); chk("c9_rise", bus.orise, 1); chk("c9_locked", bus.olocked, 0);
    step(); chk("c10_locked", bus.olocked, 1); chk("c10_oclk", bus.oclk_sd, 1);
    count_while(1'b1, n); chk("slow_high", n, 100);
    count_while(1'b0, n); chk("slow_low", n, 100);

    // Back to fast with N=4, then drop ien during the high phase.
    nx_sel = 1'b1; nx_fast = 8'd4;
    wait_rise("to_fast4");
    nx_ien = 1'b0;
    step();
    count_while(1'b1, n); chk("park_high", n, 4);
    wait_stop(n); chk("park_low", n, 4); chk("park_stop", bus.ostopped, 1);
    repeat (3) step();
    chk("parked_stop", bus.ostopped, 1); chk("parked_oclk", bus.oclk_sd, 0);
    nx_ien = 1'b1;
    step(); chk("unpark_rise", bus.orise, 1);
    step(); chk("unpark_oclk", bus.oclk_sd, 1); chk("unpark_stop", bus.ostopped, 0);

    // Divisor 0 runs as N=1: clock toggles every cycle.
    nx_fast = 8'd0;
    wait_rise("to_n1");
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("n1_oclk", bus.oclk_sd, i % 2);
      chk("n1_fall", bus.ofall, i % 2);
      chk("n1_rise", bus.orise, 1 - (i % 2));
    end

    // Divisor 3 -> 5 during a low phase takes effect one period later.
    nx_fast = 8'd3;
    wait_rise("to_n3");
    step();
    count_while(1'b1, n); chk("n3_high", n, 3);
    nx_fast = 8'd5;
    count_while(1'b0, n); chk("n3_low", n, 3);
    count_while(1'b1, n); chk("n5_high", n, 5);
    count_while(1'b0, n); chk("n5_low", n, 5);
    chk("n5_locked", bus.olocked, 1);

    // Asynchronous reset in the middle of a high phase.
    wait_rise("pre_reset");
    step(); step();
    irst = 1'b1; nx_rst = 1'b1;
    #1;
    chk("arst_oclk", bus.oclk_sd, 0);
    chk("arst_rise", bus.orise, 0);
    chk("arst_fall", bus.ofall, 0);
    chk("arst_locked", bus.olocked, 0);
    chk("arst_stop", bus.ostopped, 0);
    repeat (2) step();
    nx_rst = 1'b0;
    wait_rise("restart");
    chk("restart_cycle", k, 4);
    step(); chk("restart_oclk", bus.oclk_sd, 1); chk("restart_locked", bus.olocked, 1);

    // Random traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      if (nx_rst) nx_rst = ($urandom_range(0, 1) == 0);
      else nx_rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 19) == 0) nx_ien = ~nx_ien;
      if ($urandom_range(0, 29) == 0) nx_sel = ~nx_sel;
      if ($urandom_range(0, 24) == 0) nx_slow = DIV_W'($urandom_range(0, 6));
      if ($urandom_range(0, 24) == 0) nx_fast = DIV_W'($urandom_range(0, 6));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sd_clk_gen.md
# sd_clk_gen

Programmable, glitch-free SD card clock generator. It succeeds the PLL/DCS two-clock selector with a counter-based divider. It derives oclk_sd from the system clock using two run-time divisors (identification/slow and data/fast), switches between them without runt pulses, and can park the card clock low for flow control. It sits between the SD host controller FSMs and the SD pads, and also produces single-cycle edge strobes so CMD/DAT logic stays in the iclk domain.

## Interface
- DIV_W, 8: width of the half-period divisors.
- RST_SEL, 0: divisor selection loaded at reset (0 = slow, 1 = fast).
- iclk  in  1  system clock; all logic on its rising edge.
- irst  in  1  reset, asynchronous, active-high.
- idiv_slow  in  DIV_W  slow half-period, in iclk cycles.
- idiv_fast  in  DIV_W  fast half-period, in iclk cycles.
- isel_clk  in  1  select slow (0) or fast (1).
- ien  in  1  clock enable; 0 parks oclk_sd low.
- oclk_sd  out  1  registered SD clock.
- orise  out  1  strobe: oclk_sd goes 0->1 on the next iclk edge.
- ofall  out  1  strobe: oclk_sd goes 1->0 on the next iclk edge.
- olocked  out  1  the active divisor matches isel_clk.
- ostopped  out  1  clock parked low because ien=0.

## Operation
- States: ST_LOW (counting low phase), ST_HIGH (counting high phase), ST_PARK (low, waiting for ien).
- Effective half-period N = selected divisor, with 0 treated as 1. Range 1..2^DIV_W-1.
- Divisor latch:
  - N_act and sel_act load only at the LOW->HIGH transition, from the current isel_clk and idiv_*.
  - A full period (high then low) always uses one N_act, so every period is exactly 2*N_act when enabled.
- Counter cnt (DIV_W bits):
  - ST_HIGH: counts 0..N_act-1. At N_act-1, ofall=1, next state ST_LOW, cnt<=0.
  - ST_LOW: counts 0..N_act-1, saturating at N_act-1. Rise happens when cnt==N_act-1 and ien=1: orise=1, latch divisor, next state ST_HIGH, cnt<=0.
  - If cnt==N_act-1 and ien=0, go to ST_PARK.
- ST_PARK: oclk_sd=0, ostopped=1. On ien=1, orise=1 that cycle, latch, go to ST_HIGH. The low phase is therefore never shorter than N_act.
- ien=0 during ST_HIGH: the high phase completes normally, then the low phase runs and the block parks. There are no truncated pulses.
- olocked:
  - 0 in reset, and 0 in any cycle where isel_clk != sel_act.
  - Returns to 1 on the cycle after the rise that latches the matching selection.
  - An idiv change without a sel change does not drop olocked.
- isel_clk toggling back before a rise: olocked returns high, because sel_act never changed.
- Simultaneous ien rise and sel change in ST_PARK: the new selection is latched at that rise.

## Timing
- Reset values: oclk_sd=0, orise=0, ofall=0, olocked=0, ostopped=0, state ST_LOW, cnt=0, sel_act=RST_SEL, N_act=max(1, divisor for RST_SEL sampled at first clock).
- After irst deasserts with ien=1: first orise is in cycle N_act-1; oclk_sd is high from cycle N_act.
- orise/ofall are combinational-from-state but registered-aligned: the strobe is high exactly one iclk cycle, the cycle before the oclk_sd edge.
- With N=1: oclk_sd = iclk/2, and orise/ofall alternate every cycle.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). A pending switch is discarded.

## Structure
- Package sd_clk_pkg: state enum (ST_LOW, ST_HIGH, ST_PARK), default DIV_W, and the divisor-zero clamp function.
- One sub-module is natural: sd_clk_half_cnt. It is a saturating half-period counter with load and terminal-count flag. The FSM and latches stay in sd_clk_gen.
- Target size: roughly 150-250 lines total.

## Test plan
- Reset, RST_SEL=1, idiv_fast=2, ien=1 -> oclk_sd period 4 cycles, 50% duty; first orise at cycle 1 after reset release; olocked=1 after first rise.
- idiv_slow=100, idiv_fast=2, switch isel 1->0 mid high phase -> current fast period completes, olocked=0 until next rise, then high/low phases of 100 cycles each; no pulse shorter than 2 cycles.
- ien=0 mid high phase (N=4) -> high phase finishes at 4 cycles, low lasts ≥4, ostopped=1; ien=1 -> orise same cycle, clock resumes.
- idiv_fast=0 -> behaves as N=1; oclk_sd toggles every cycle; orise/ofall alternate.
- idiv_fast changed 3->5 during low phase -> current period stays 3/3; next period is 5/5; olocked stays 1.
- irst asserted mid high phase -> oclk_sd=0 and all strobes 0 immediately; normal restart after release.
